// File: rtl/spike_rate_decoder.sv
// Spike-train receiver: counts spikes and finds the first-spike index over
// programmable back-to-back windows, presenting results on a valid/ready port.
module spike_rate_decoder #(
  parameter int unsigned WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIN_W-1:0] spike_count,
  output logic [WIN_W-1:0] first_spike,
  output logic             overrun
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] idx_q, idx_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] count_q, count_d;
  logic [WIN_W-1:0] fs_q, fs_d;
  logic             found_q, found_d;

  logic             out_valid_q, out_valid_d;
  logic [WIN_W-1:0] res_count_q, res_count_d;
  logic [WIN_W-1:0] res_fs_q, res_fs_d;
  logic             overrun_q, overrun_d;

  logic             at_first;
  logic             is_last;
  logic             take;
  logic             win_end;
  logic             found_next;
  logic [WIN_W-1:0] cnt_next;
  logic [WIN_W-1:0] fs_next;
  logic [WIN_W-1:0] res_fs;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      len_q       <= '0;
      count_q     <= '0;
      fs_q        <= '0;
      found_q     <= 1'b0;
      out_valid_q <= 1'b0;
      res_count_q <= '0;
      res_fs_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      count_q     <= count_d;
      fs_q        <= fs_d;
      found_q     <= found_d;
      out_valid_q <= out_valid_d;
      res_count_q <= res_count_d;
      res_fs_q    <= res_fs_d;
      overrun_q   <= overrun_d;
    end
  end

  // Sample decode. In StCount, idx_q == 0 marks the sample 0 of a back-to-back
  // window, which behaves exactly like a start from StIdle.
  always_comb begin
    at_first   = (state_q == StIdle) || (idx_q == '0);
    is_last    = at_first ? (window_len == WIN_W'(1)) : (idx_q == len_q - WIN_W'(1));
    take       = at_first ? (enable && (window_len != '0)) : (enable || is_last);
    win_end    = take && is_last;
    cnt_next   = (at_first ? '0 : count_q) + WIN_W'(spike_in);
    found_next = (!at_first && found_q) || spike_in;
    fs_next    = (!at_first && found_q) ? fs_q : (at_first ? '0 : idx_q);
    res_fs     = found_next ? fs_next : '1;
  end

  // Next-state process
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    count_d = count_q;
    fs_d    = fs_q;
    found_d = found_q;
    if (!take) begin
      // Idle, or an abort: partial window is discarded.
      state_d = StIdle;
      idx_d   = '0;
      count_d = '0;
      fs_d    = '0;
      found_d = 1'b0;
    end else if (win_end) begin
      state_d = enable ? StCount : StIdle;
      idx_d   = '0;
      count_d = '0;
      fs_d    = '0;
      found_d = 1'b0;
      if (at_first) begin
        len_d = window_len;
      end
    end else begin
      state_d = StCount;
      idx_d   = idx_q + WIN_W'(1);
      count_d = cnt_next;
      fs_d    = fs_next;
      found_d = found_next;
      if (at_first) begin
        len_d = window_len;
      end
    end
  end

  // Output process: result register and handshake
  always_comb begin
    out_valid_d = out_valid_q;
    res_count_d = res_count_q;
    res_fs_d    = res_fs_q;
    overrun_d   = overrun_q;
    if (win_end && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      res_count_d = cnt_next;
      res_fs_d    = res_fs;
    end else begin
      if (win_end) begin
        overrun_d = 1'b1;
      end
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign spike_count = res_count_q;
  assign first_spike = res_fs_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: windowed sample-list reference model feeding a
// result scoreboard, with directed scenarios followed by random traffic.
module tb_spike_rate_decoder;

  localparam int unsigned WIN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             spike_in;
  logic             enable;
  logic [WIN_W-1:0] window_len;
  logic             out_ready;
  logic             out_valid;
  logic [WIN_W-1:0] spike_count;
  logic [WIN_W-1:0] first_spike;
  logic             overrun;

  spike_rate_decoder #(.WIN_W(WIN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .enable      (enable),
    .window_len  (window_len),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .spike_count (spike_count),
    .first_spike (first_spike),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int fs;
  } res_t;

  res_t exp_q[$];
  bit   win[$];
  int   mlen;
  bit   m_valid;
  bit   m_over;
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect samples of the open window as a list; at window
  // end the count is the sum and the first spike is the first index holding 1.
  initial begin
    res_t r;
    bit   got;
    bit   consume;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        win.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_over  = 1'b0;
      end else begin
        consume = m_valid && out_ready;
        got     = 1'b0;
        if (win.size() == 0) begin
          if (enable && window_len != 0) begin
            mlen = int'(window_len);
            win.push_back(spike_in);
          end
        end else if (!enable && win.size() + 1 < mlen) begin
          win.delete();
        end else begin
          win.push_back(spike_in);
        end
        if (win.size() != 0 && win.size() == mlen) begin
          r.cnt = 0;
          r.fs  = 255;
          for (int i = mlen - 1; i >= 0; i--) begin
            r.cnt += int'(win[i]);
            if (win[i]) r.fs = i;
          end
          got = 1'b1;
          win.delete();
        end
        if (got && (!m_valid || consume)) begin
          exp_q.push_back(r);
          m_valid = 1'b1;
        end else begin
          if (got) m_over = 1'b1;
          if (consume) m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: away from the active edge, compare the presented result against
  // the scoreboard head and retire it when the consumer accepts.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("out_valid", int'(out_valid), int'(m_valid));
        check("overrun", int'(overrun), int'(m_over));
        if (out_valid && m_valid) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
          end else begin
            check("spike_count", int'(spike_count), exp_q[0].cnt);
            check("first_spike", int'(first_spike), exp_q[0].fs);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit en, input int len, input bit spk, input bit rdy);
    enable     = en;
    window_len = WIN_W'(len);
    spike_in   = spk;
    out_ready  = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_spike_count", int'(spike_count), 0);
    check("rst_first_spike", int'(first_spike), 0);
    check("rst_overrun", int'(overrun), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    window_len = '0;
    spike_in   = 1'b0;
    out_ready  = 1'b0;
    @(posedge clk);
    #2;
    do_reset();

    // len 8, spikes at samples 2,4,5 -> count 3, first 2
    pat = 8'b0011_0100;
    for (int i = 0; i < 8; i++) cyc(1, 8, pat[i], 1);
    check("t1_valid", int'(out_valid), 1);
    check("t1_count", int'(spike_count), 3);
    check("t1_first", int'(first_spike), 2);
    cyc(0, 8, 0, 1);
    check("t1_valid_fall", int'(out_valid), 0);
    cyc(0, 8, 0, 1);

    // len 4 silent window, then len 1 with continuous spikes
    for (int i = 0; i < 4; i++) cyc(1, 4, 0, 1);
    check("t2_first_none", int'(first_spike), 255);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1);
    cyc(0, 1, 0, 1);

    // back-to-back len 3 windows, always spiking
    for (int i = 0; i < 9; i++) cyc(1, 3, 1, 1);
    cyc(0, 3, 0, 1);
    cyc(0, 3, 0, 1);

    // stall across two window ends -> second dropped, overrun sticks
    pat = 8'b1111_0011;
    for (int i = 0; i < 8; i++) cyc(1, 4, pat[i], 0);
    cyc(0, 4, 0, 0);
    check("t4_overrun", int'(overrun), 1);
    check("t4_held", int'(spike_count), 2);
    cyc(0, 4, 0, 1);
    cyc(0, 4, 0, 1);
    do_reset();

    // window end coincides with acceptance of a pending result
    for (int i = 0; i < 2; i++) cyc(1, 2, 1, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 2, 1, 1);
    check("t5_valid_kept", int'(out_valid), 1);
    check("t5_new_first", int'(first_spike), 1);
    cyc(0, 2, 0, 1);
    cyc(0, 2, 0, 1);

    // abort at sample 2 of a len 8 window
    cyc(1, 8, 1, 1);
    cyc(1, 8, 1, 1);
    cyc(0, 8, 1, 1);
    for (int i = 0; i < 8; i++) cyc(0, 8, 1, 1);
    check("t6_abort_no_out", int'(out_valid), 0);

    // reset mid-window with a pending result, then a clean window
    cyc(1, 2, 1, 0);
    cyc(1, 2, 1, 0);
    cyc(1, 2, 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 3, i == 1, 1);
    check("t6_clean_first", int'(first_spike), 1);
    cyc(0, 3, 0, 1);

    // random traffic
    begin
      int len;
      len = 3;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 6);
        if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
        cyc($urandom_range(0, 19) != 0, len, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < 7);
      end
      rst_n = 1'b1;
    end

    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive-side counterpart to the integrate-and-fire neuron: turns a 1-bit spike train back into numbers.
- Observes the spike train over programmable windows. For each window it reports the spike count (rate code) and the time to first spike (latency code).
- Results are presented on a valid/ready output port, so a downstream consumer or readout mux can stall without corrupting counting.

Parameters:
- WIN_W, 8, width of window length, sample index, spike count and first-spike time.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- spike_in  input  1  spike train; one sample per clock while a window is open.
- enable  input  1  1 = run windows back-to-back; 0 = idle or abort.
- window_len  input  WIN_W  window length in samples; latched on sample 0 of each window.
- out_ready  input  1  consumer accepts the result when out_valid=1 and out_ready=1.
- out_valid  output  1  result register holds an unconsumed result.
- spike_count  output  WIN_W  number of spikes in the window, 0..len.
- first_spike  output  WIN_W  sample index (0..len-1) of the first spike; all-ones if the window had no spike.
- overrun  output  1  sticky; a completed window was dropped because out_valid was still pending.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; idx, count, first-spike tracking and latched length cleared. out_valid=0, spike_count=0, first_spike=0, overrun=0. Reset mid-window discards all partial and pending results.
- States: IDLE and COUNT.
- IDLE -> COUNT:
  - Taken on an edge where enable=1 and window_len!=0.
  - That edge is sample 0: latches len=window_len and samples spike_in.
  - If enable=1 and window_len=0, stay in IDLE with no sampling.
- Sampling: each edge in a window is one sample, k=0..len-1.
  - If spike_in=1: count+=1.
  - If spike_in=1 and no earlier spike this window: fs=k.
  - Width WIN_W suffices for count; no saturation needed because count<=len<=2^WIN_W-1.
- Window end is the edge of sample k=len-1 (for len=1, the same edge as sample 0).
  - Result count/fs (fs=all-ones if no spike) goes to the output register per the handshake rules below.
  - If enable=1 at that edge: the next edge is sample 0 of a new window, with window_len re-latched. There are no dead cycles between windows.
  - If enable=0 at that edge: go to IDLE.
- Enable dropped mid-window (enable=0 at an edge with k<len-1): abort. Partial window discarded, go to IDLE, no output, overrun unaffected. Output register untouched.
- window_len changes mid-window have no effect until the next sample 0.
- Output handshake:
  - out_valid rises the cycle after the window-end edge.
  - spike_count and first_spike stay stable while out_valid=1 and out_ready=0.
  - An edge with out_valid=1 and out_ready=1 consumes the result. out_valid falls next cycle unless a new result loads on the same edge.
  - Window end with out_valid=0, or with out_valid=1 and out_ready=1 on the same edge: new result loads and out_valid=1. No overrun.
  - Window end with out_valid=1 and out_ready=0: new result dropped, old result kept, overrun set to 1. overrun stays 1 until reset.
- Latency: the result for a window is visible 1 clock after its last sample edge.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan:
- Reset, then enable=1, window_len=8, spike_in=0,0,1,0,1,1,0,0, out_ready=1 -> one cycle after the 8th sample: out_valid=1, spike_count=3, first_spike=2; out_valid=0 the following cycle.
- window_len=4, all-zero spikes -> spike_count=0, first_spike=8'hFF. Then window_len=1 with spike_in=1 -> a result each cycle: spike_count=1, first_spike=0.
- enable held high, window_len=3, spike_in=1 continuously, out_ready=1 -> back-to-back results every 3 clocks, each spike_count=3, first_spike=0, no gap; overrun=0.
- out_ready=0 across two window ends (len=4; windows of 2 then 4 spikes) -> first result (2) held stable, second dropped, overrun=1. Raise out_ready -> accept 2; overrun stays 1.
- Window end coincides with out_valid=1 and out_ready=1 -> old result accepted, new result loaded same edge, out_valid stays 1, overrun=0.
- enable dropped at sample 2 of a len=8 window, and separately rst_n=0 mid-window with a pending result -> abort yields no output. Reset clears out_valid, spike_count, first_spike and overrun to 0; next window starts cleanly from sample 0.
